wall_game_fsm: RTL



---
 rtl/wall_game_fsm.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wall_game_fsm.sv
// Game sequencer ahead of the graphics controller: counts collision pixels per frame,
// steps the wall depth on a frame cadence and decides lose/win/idle.
module wall_game_fsm #(
   parameter int ACTIVE_H_PIXELS     = 1280,
   parameter int ACTIVE_LINES        = 720,
   parameter int MAX_WALL_DEPTH      = 75,
   parameter int GOAL_DEPTH          = 60,
   parameter int GOAL_DEPTH_DELTA    = 10,
   parameter int FRAMES_PER_STEP     = 4,
   parameter int COLLISION_THRESHOLD = 2000,
   parameter int RESULT_FRAMES       = 180
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        is_collision,
   input  logic        start_in,
   output logic [2:0]  game_state_out,
   output logic [7:0]  wall_depth_out,
   output logic [19:0] collision_count_out,
   output logic        frame_tick_out
);

   typedef enum logic [2:0] {
      ST_OVER    = 3'd0,
      ST_PLAYING = 3'd1,
      ST_WIN     = 3'd2,
      ST_IDLE    = 3'd3
   } state_t;

   localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);
   localparam int RES_W  = $clog2(RESULT_FRAMES + 1);

   localparam logic [10:0]       H_ACT     = 11'(ACTIVE_H_PIXELS);
   localparam logic [9:0]        V_ACT     = 10'(ACTIVE_LINES);
   localparam logic [7:0]        MAX_D     = 8'(MAX_WALL_DEPTH);
   localparam logic [7:0]        LOSE_D    = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
   localparam logic [7:0]        WIN_D     = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
   localparam logic [19:0]       THRESH    = 20'(COLLISION_THRESHOLD);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
   localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(RESULT_FRAMES - 1);

   state_t            state;
   logic [19:0]       coll_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic [RES_W-1:0]  res_cnt;
   logic              start_q;

   logic tick_cond;
   logic pixel_hit;
   logic start_rise;
   logic lose_now;

   assign tick_cond  = (hcount_in == 11'd0) && (vcount_in == V_ACT);
   assign pixel_hit  = is_collision && (hcount_in < H_ACT) && (vcount_in < V_ACT);
   assign start_rise = start_in && !start_q;
   // The lose test looks at the count being latched on this tick, not the stale output.
   assign lose_now   = (wall_depth_out <= LOSE_D) && (coll_cnt > THRESH);

   assign game_state_out = state;

   // NOTE: every register here updates with <= so all decisions read pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state               <= ST_IDLE;
         wall_depth_out      <= MAX_D;
         collision_count_out <= '0;
         frame_tick_out      <= 1'b0;
         coll_cnt            <= '0;
         step_cnt            <= '0;
         res_cnt             <= '0;
         start_q             <= 1'b0;
      end else begin
         start_q        <= start_in;
         frame_tick_out <= tick_cond;

         // Restart with the current pixel so no hit is lost on the tick cycle.
         if (frame_tick_out) begin
            collision_count_out <= coll_cnt;
            coll_cnt            <= pixel_hit ? 20'd1 : 20'd0;
         end else if (pixel_hit && !(&coll_cnt)) begin
            coll_cnt <= coll_cnt + 20'd1;
         end

         case (state)
            ST_IDLE: begin
               wall_depth_out <= MAX_D;
               if (start_rise) begin
                  state    <= ST_PLAYING;
                  step_cnt <= '0;
                  res_cnt  <= '0;
               end
            end

            ST_PLAYING: begin
               if (frame_tick_out) begin
                  if (lose_now) begin
                     state   <= ST_OVER;
                     res_cnt <= '0;
                  end else if (step_cnt == STEP_LAST) begin
                     step_cnt <= '0;
                     if (wall_depth_out <= WIN_D) begin
                        state   <= ST_WIN;
                        res_cnt <= '0;
                     end else begin
                        wall_depth_out <= wall_depth_out - 8'd1;
                     end
                  end else begin
                     step_cnt <= step_cnt + STEP_W'(1);
                  end
               end
            end

            ST_OVER, ST_WIN: begin
               if (start_rise) begin
                  state          <= ST_IDLE;
                  wall_depth_out <= MAX_D;
                  step_cnt       <= '0;
                  res_cnt        <= '0;
               end else if (frame_tick_out) begin
                  if (res_cnt == RES_LAST) begin
                     state          <= ST_IDLE;
                     wall_depth_out <= MAX_D;
                     res_cnt        <= '0;
                  end else begin
                     res_cnt <= res_cnt + RES_W'(1);
                  end
               end
            end

            default: begin
               state          <= ST_IDLE;
               wall_depth_out <= MAX_D;
            end
         endcase
      end
   end

endmodule
